button_event_gen: RTL and testbench

- Sits directly downstream of the push-button debouncer. Consumes its five stable, debounced button levels.
- Produces single-cycle press events for the timer/VGA control logic. Events come from a press edge plus auto-repeat while a button is held, and single-cycle release events on release.
- One independent channel per button. All channels share one clock and one reset.

---
 rtl/button_event_pkg.sv | 37 +++
 rtl/button_event_cell.sv | 119 +++++++++++
 rtl/button_event_gen.sv | 61 ++++++
 tb/tb_button_event_gen.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/button_event_pkg.sv
// -----------------------------------------------------------------------------
// button_event_pkg
// Shared definitions for the button event generator:
//   - btn_ev_state_t : per-channel FSM state encoding
//   - clog2_int / max_int : elaboration-time helpers for counter sizing
//   - default repeat delay/period constants for the 25 MHz and 50 MHz builds
//     (1 s initial delay, 200 ms repeat period)
// No ports (package).
// -----------------------------------------------------------------------------
package button_event_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2
   } btn_ev_state_t;

   localparam int DELAY_25M  = 25_000_000;
   localparam int PERIOD_25M = 5_000_000;
   localparam int DELAY_50M  = 50_000_000;
   localparam int PERIOD_50M = 10_000_000;

   // Smallest width able to hold values 0..value-1; never less than 1 bit.
   function automatic int clog2_int(input int value);
      int w;
      w = 0;
      while ((32'sd1 <<< w) < value) begin
         w = w + 1;
      end
      return (w < 1) ? 1 : w;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_event_cell.sv
// -----------------------------------------------------------------------------
// button_event_cell
// One button channel: edge detect, hold counter and IDLE/HOLD/REPEAT FSM.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   btn          : debounced level, 1 = pressed
//   press        : registered one-cycle pulse on press edge and each repeat
//   release_evt  : registered one-cycle pulse on release edge
//   repeating    : registered level, 1 while in REPEAT
//   press_next   : value press takes at the next edge (lets the top register
//                  an OR of all channels aligned with press)
// -----------------------------------------------------------------------------
module button_event_cell
   import button_event_pkg::*;
#(
   parameter int REPEAT_DELAY  = DELAY_25M,
   parameter int REPEAT_PERIOD = PERIOD_25M,
   parameter bit REPEAT_EN     = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press,
   output logic release_evt,
   output logic repeating,
   output logic press_next
);

   localparam int CNT_W = clog2_int(max_int(REPEAT_DELAY, REPEAT_PERIOD));
   localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(32'd0);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'd1);

   btn_ev_state_t    state_r, state_nxt_s;
   logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
   logic             prev_r;
   logic             press_r, release_r, repeating_r;
   logic             press_nxt_s, release_nxt_s;

   // Next-state, counter and event decode for this channel.
   always_comb begin
      state_nxt_s   = state_r;
      cnt_nxt_s     = cnt_r;
      press_nxt_s   = 1'b0;
      release_nxt_s = 1'b0;
      case (state_r)
         IDLE: begin
            // prev is forced high by reset, so a button held through reset
            // must be released before it can produce a press.
            if (btn && !prev_r) begin
               press_nxt_s = 1'b1;
               cnt_nxt_s   = CNT_ZERO;
               state_nxt_s = HOLD;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         HOLD: begin
            // Release is tested first so it wins over a terminal count.
            if (!btn) begin
               release_nxt_s = 1'b1;
               cnt_nxt_s     = CNT_ZERO;
               state_nxt_s   = IDLE;
            end else if (REPEAT_EN && (cnt_r == DELAY_LAST)) begin
               press_nxt_s = 1'b1;
               cnt_nxt_s   = CNT_ZERO;
               state_nxt_s = REPEAT;
            end else if (REPEAT_EN) begin
               cnt_nxt_s = cnt_r + CNT_ONE;
            end else begin
               // Repeat disabled: counter frozen, HOLD just waits for release.
               cnt_nxt_s = cnt_r;
            end
         end
         REPEAT: begin
            if (!btn) begin
               release_nxt_s = 1'b1;
               cnt_nxt_s     = CNT_ZERO;
               state_nxt_s   = IDLE;
            end else if (cnt_r == PERIOD_LAST) begin
               press_nxt_s = 1'b1;
               cnt_nxt_s   = CNT_ZERO;
            end else begin
               cnt_nxt_s = cnt_r + CNT_ONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = CNT_ZERO;
         end
      endcase
   end

   // State, counter, previous level and registered event outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         cnt_r       <= CNT_ZERO;
         prev_r      <= 1'b1;
         press_r     <= 1'b0;
         release_r   <= 1'b0;
         repeating_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         prev_r      <= btn;
         press_r     <= press_nxt_s;
         release_r   <= release_nxt_s;
         repeating_r <= (state_nxt_s == REPEAT);
      end
   end

   assign press       = press_r;
   assign release_evt = release_r;
   assign repeating   = repeating_r;
   assign press_next  = press_nxt_s;

endmodule

// File: rtl/button_event_gen.sv
// -----------------------------------------------------------------------------
// button_event_gen
// Turns debounced button levels into press / auto-repeat / release events,
// one independent channel per button.
// Ports:
//   clk           : system clock
//   rst           : synchronous active-high reset
//   btn_state     : [N_BTN] debounced levels, 1 = pressed
//   btn_press     : [N_BTN] one-cycle pulse on press edge and each repeat
//   btn_release   : [N_BTN] one-cycle pulse on release edge
//   btn_repeating : [N_BTN] level, 1 while the channel auto-repeats
//   any_press     : registered OR of btn_press, aligned with btn_press
// -----------------------------------------------------------------------------
module button_event_gen
   import button_event_pkg::*;
#(
   parameter int               N_BTN         = 5,
   parameter int               REPEAT_DELAY  = DELAY_25M,
   parameter int               REPEAT_PERIOD = PERIOD_25M,
   parameter logic [N_BTN-1:0] REPEAT_MASK   = {N_BTN{1'b1}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_state,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_repeating,
   output logic             any_press
);

   logic [N_BTN-1:0] press_next_s;
   logic             any_press_r;

   for (genvar i = 0; i < N_BTN; i++) begin : g_chan
      button_event_cell #(
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD),
         .REPEAT_EN     (REPEAT_MASK[i])
      ) u_cell (
         .clk         (clk),
         .rst         (rst),
         .btn         (btn_state[i]),
         .press       (btn_press[i]),
         .release_evt (btn_release[i]),
         .repeating   (btn_repeating[i]),
         .press_next  (press_next_s[i])
      );
   end

   // OR of the cells' next press values, registered so it lines up with btn_press.
   always_ff @(posedge clk) begin
      if (rst) begin
         any_press_r <= 1'b0;
      end else begin
         any_press_r <= |press_next_s;
      end
   end

   assign any_press = any_press_r;

endmodule

// File: tb/tb_button_event_gen.sv
// -----------------------------------------------------------------------------
// tb_button_event_gen
// Directed bench for button_event_gen with REPEAT_DELAY=8, REPEAT_PERIOD=4.
// dut_a has repeat enabled on all channels, dut_b has it disabled on channel 0.
// Inputs change and outputs are sampled 1 ns after each rising edge, so the
// values checked after tick() are the ones registered at that edge.
// -----------------------------------------------------------------------------
module tb_button_event_gen;

   logic       clk;
   logic       rst;
   logic [4:0] btn_a, btn_b;
   logic [4:0] press_a, release_a, rep_a;
   logic [4:0] press_b, release_b, rep_b;
   logic       any_a, any_b;

   int n_checks;
   int n_errors;

   button_event_gen #(
      .N_BTN(5), .REPEAT_DELAY(8), .REPEAT_PERIOD(4), .REPEAT_MASK(5'b11111)
   ) dut_a (
      .clk(clk), .rst(rst), .btn_state(btn_a), .btn_press(press_a),
      .btn_release(release_a), .btn_repeating(rep_a), .any_press(any_a)
   );

   button_event_gen #(
      .N_BTN(5), .REPEAT_DELAY(8), .REPEAT_PERIOD(4), .REPEAT_MASK(5'b11110)
   ) dut_b (
      .clk(clk), .rst(rst), .btn_state(btn_b), .btn_press(press_b),
      .btn_release(release_b), .btn_repeating(rep_b), .any_press(any_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_a(input string tag, input logic [4:0] p, input logic [4:0] r,
                          input logic [4:0] rp);
      check_eq({tag, "_press"},   {27'd0, press_a},   {27'd0, p});
      check_eq({tag, "_release"}, {27'd0, release_a}, {27'd0, r});
      check_eq({tag, "_repeat"},  {27'd0, rep_a},     {27'd0, rp});
      check_eq({tag, "_any"},     {31'd0, any_a},     {31'd0, (p != 5'd0)});
   endtask

   initial begin
      logic [4:0] ep, er, erp;
      int         presses;
      n_checks = 0;
      n_errors = 0;
      rst   = 1'b1;
      btn_a = 5'd0;
      btn_b = 5'd0;
      tick();
      tick();
      check_a("reset", 5'd0, 5'd0, 5'd0);
      rst = 1'b0;
      tick();
      tick();

      // Single press/release on channel 0: high at E0, low sampled at E5.
      btn_a = 5'b00001;
      for (int k = 0; k <= 5; k++) begin
         if (k == 5) btn_a = 5'b00000;
         tick();
         ep = (k == 0) ? 5'b00001 : 5'b00000;
         er = (k == 5) ? 5'b00001 : 5'b00000;
         check_a($sformatf("single_e%0d", k), ep, er, 5'd0);
      end
      tick();

      // Long hold on channel 1: presses at E0, E8, E12, E16; low sampled at E20.
      btn_a = 5'b00010;
      for (int k = 0; k <= 20; k++) begin
         if (k == 20) btn_a = 5'b00000;
         tick();
         ep  = (k == 0 || k == 8 || k == 12 || k == 16) ? 5'b00010 : 5'b00000;
         er  = (k == 20) ? 5'b00010 : 5'b00000;
         erp = (k >= 8 && k < 20) ? 5'b00010 : 5'b00000;
         check_a($sformatf("hold_e%0d", k), ep, er, erp);
      end
      tick();

      // Channel 2 held through reset: no events while held. The channel sits
      // in IDLE, so dropping it gives no release; re-raising gives a press.
      btn_a = 5'b00100;
      rst   = 1'b1;
      tick(); tick(); tick();
      check_a("thru_rst_in_reset", 5'd0, 5'd0, 5'd0);
      rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         check_a($sformatf("thru_rst_held%0d", k), 5'd0, 5'd0, 5'd0);
      end
      btn_a = 5'b00000;
      tick();
      check_a("thru_rst_drop", 5'd0, 5'd0, 5'd0);
      tick();
      btn_a = 5'b00100;
      tick();
      check_a("thru_rst_repress", 5'b00100, 5'd0, 5'd0);
      btn_a = 5'b00000;
      tick();
      check_a("thru_rst_release", 5'd0, 5'b00100, 5'd0);
      tick();

      // Channels 0 and 4 together; channel 0 drops on its E8 terminal edge
      // (release only) while channel 4 takes its first repeat on that edge.
      btn_a = 5'b10001;
      tick();
      check_a("simul_e0", 5'b10001, 5'd0, 5'd0);
      for (int k = 1; k <= 8; k++) begin
         if (k == 8) btn_a = 5'b10000;
         tick();
         ep  = (k == 8) ? 5'b10000 : 5'b00000;
         er  = (k == 8) ? 5'b00001 : 5'b00000;
         erp = (k == 8) ? 5'b10000 : 5'b00000;
         check_a($sformatf("simul_e%0d", k), ep, er, erp);
      end
      btn_a = 5'b00000;
      tick();
      check_a("simul_rel4", 5'd0, 5'b10000, 5'd0);
      tick();

      // Mask off on dut_b channel 0: held 30 cycles, one press, one release.
      btn_b   = 5'b00001;
      presses = 0;
      for (int k = 0; k <= 30; k++) begin
         if (k == 30) btn_b = 5'b00000;
         tick();
         if (press_b[0]) presses = presses + 1;
         check_eq($sformatf("mask_rep_e%0d", k), {27'd0, rep_b}, 32'd0);
         check_eq($sformatf("mask_rel_e%0d", k), {27'd0, release_b},
                  (k == 30) ? 32'd1 : 32'd0);
         check_eq($sformatf("mask_any_e%0d", k), {31'd0, any_b},
                  (k == 0) ? 32'd1 : 32'd0);
      end
      check_eq("mask_press_count", presses, 32'd1);
      tick();

      // Channel 3 into REPEAT, then reset on E14 while still held.
      btn_a = 5'b01000;
      for (int k = 0; k <= 13; k++) begin
         tick();
         ep  = (k == 0 || k == 8 || k == 12) ? 5'b01000 : 5'b00000;
         erp = (k >= 8) ? 5'b01000 : 5'b00000;
         check_a($sformatf("rstrep_e%0d", k), ep, 5'd0, erp);
      end
      rst = 1'b1;
      tick();
      check_a("rstrep_cleared", 5'd0, 5'd0, 5'd0);
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         check_a($sformatf("rstrep_after%0d", k), 5'd0, 5'd0, 5'd0);
      end
      btn_a = 5'b00000;
      tick();
      check_a("rstrep_drop", 5'd0, 5'd0, 5'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
